// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared types and constants for the 7-segment scan controller.
//   scan_state_t : scheduler states (IDLE, BLANK, DRIVE)
//   SEG_0..SEG_9 : active-high segment patterns {g,f,e,d,c,b,a}
//   SEG_OFF      : all segments dark
//   max_int      : constant helper used to size the shared cycle counter
// -----------------------------------------------------------------------------
package seg_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BLANK,
      DRIVE
   } scan_state_t;

   localparam logic [6:0] SEG_0   = 7'h3F;
   localparam logic [6:0] SEG_1   = 7'h06;
   localparam logic [6:0] SEG_2   = 7'h5B;
   localparam logic [6:0] SEG_3   = 7'h4F;
   localparam logic [6:0] SEG_4   = 7'h66;
   localparam logic [6:0] SEG_5   = 7'h6D;
   localparam logic [6:0] SEG_6   = 7'h7D;
   localparam logic [6:0] SEG_7   = 7'h07;
   localparam logic [6:0] SEG_8   = 7'h7F;
   localparam logic [6:0] SEG_9   = 7'h6F;
   localparam logic [6:0] SEG_OFF = 7'h00;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// -----------------------------------------------------------------------------
// bcd_to_seg7
// Combinational BCD to 7-segment decoder, active-high output.
//   bcd : 4-bit digit value; codes 10..15 are not digits and decode dark
//   seg : {g,f,e,d,c,b,a}, 1 = segment lit
// -----------------------------------------------------------------------------
module bcd_to_seg7
   import seg_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_OFF;
      endcase
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
// Round-robin scheduler for a shared 7-segment bus. Each digit gets
// BLANK_CYCLES of all-off dead time followed by DWELL_CYCLES of drive. A BCD
// snapshot is taken once per frame through a valid/ready handshake so that a
// frame never mixes old and new digits.
//
// Ports:
//   clk, rst     : clock (rising edge), asynchronous active-high reset
//   en           : scan enable; low forces IDLE on the next edge
//   cathod       : 1 = common-cathode (active-high pins), 0 = common-anode
//   lz_blank     : 1 = suppress leading zeros (digit 0 always shown)
//   bcd_in       : packed BCD, digit i at [4i+3:4i]
//   dp_mask      : decimal point per digit, captured with the snapshot
//   bcd_valid    : bcd_in/dp_mask valid
//   bcd_ready    : snapshot slot open (IDLE, or last DRIVE cycle of the frame)
//   seg, an, dp  : segment, digit-select and decimal-point pins
//   other_an     : unused board anodes, held inactive
//   frame_start  : one-cycle pulse on the first BLANK cycle of digit 0
//   digit_idx    : digit currently scheduled
// -----------------------------------------------------------------------------
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int DIGITS       = 3,
   parameter int DWELL_CYCLES = 1000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic                       cathod,
   input  logic                       lz_blank,
   input  logic [4*DIGITS-1:0]        bcd_in,
   input  logic [DIGITS-1:0]          dp_mask,
   input  logic                       bcd_valid,
   output logic                       bcd_ready,
   output logic [6:0]                 seg,
   output logic [DIGITS-1:0]          an,
   output logic                       dp,
   output logic [4:0]                 other_an,
   output logic                       frame_start,
   output logic [$clog2(DIGITS)-1:0]  digit_idx
);

   localparam int CNT_MAX = max_int(DWELL_CYCLES, BLANK_CYCLES);
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int IDX_W   = $clog2(DIGITS);

   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

   scan_state_t          state, state_nxt;
   logic [CNT_W-1:0]     cnt, cnt_nxt;
   logic [IDX_W-1:0]     idx_nxt;

   logic [4*DIGITS-1:0]  shadow_bcd;
   logic [DIGITS-1:0]    shadow_dp;

   logic [3:0]           cur_bcd;
   logic [6:0]           cur_seg;
   logic [DIGITS-1:0]    zero_run;
   logic                 upper_zero;

   logic [6:0]           seg_raw;
   logic [DIGITS-1:0]    an_raw;
   logic                 dp_raw;
   logic                 fs_raw;

   // ---------------------------------------------------------------------------
   // Scheduler next-state logic
   // ---------------------------------------------------------------------------
   // NOTE: every signal gets a default at the top of an always_comb so that no
   // path leaves it unassigned; an unassigned path would infer a latch.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      idx_nxt   = digit_idx;

      if (!en) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
         idx_nxt   = '0;
      end else begin
         unique case (state)
            IDLE: begin
               state_nxt = BLANK;
               cnt_nxt   = '0;
               idx_nxt   = '0;
            end
            BLANK: begin
               if (cnt == BLANK_LAST) begin
                  state_nxt = DRIVE;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            DRIVE: begin
               if (cnt == DWELL_LAST) begin
                  state_nxt = BLANK;
                  cnt_nxt   = '0;
                  idx_nxt   = (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            default: begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
               idx_nxt   = '0;
            end
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of block order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         digit_idx <= '0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         digit_idx <= idx_nxt;
      end
   end

   // Open only while nothing is being shown, or on the very last drive cycle
   // of the frame, so a new snapshot always lands between frames.
   assign bcd_ready = (state == IDLE) ||
                      ((state == DRIVE) && (cnt == DWELL_LAST) && (digit_idx == IDX_LAST));

   // ---------------------------------------------------------------------------
   // Snapshot shadow register
   // ---------------------------------------------------------------------------
   // NOTE: this storage is reset on purpose: the first frame after reset must
   // show zeros rather than power-up contents.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_bcd <= '0;
         shadow_dp  <= '0;
      end else if (bcd_valid && bcd_ready) begin
         shadow_bcd <= bcd_in;
         shadow_dp  <= dp_mask;
      end
   end

   // ---------------------------------------------------------------------------
   // Decode and leading-zero suppression
   // ---------------------------------------------------------------------------
   // zero_run[i] is set when digit i and every digit above it are zero.
   always_comb begin
      upper_zero = 1'b1;
      zero_run   = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         upper_zero  = upper_zero & (shadow_bcd[4*i +: 4] == 4'd0);
         zero_run[i] = upper_zero;
      end
   end

   assign cur_bcd = shadow_bcd[4*int'(idx_nxt) +: 4];

   bcd_to_seg7 u_dec (
      .bcd (cur_bcd),
      .seg (cur_seg)
   );

   // Output pins are registered from the next state, so after each edge they
   // describe exactly the state the scheduler has just entered.
   always_comb begin
      seg_raw = SEG_OFF;
      an_raw  = '0;
      dp_raw  = 1'b0;
      fs_raw  = (state_nxt == BLANK) && (cnt_nxt == '0) && (idx_nxt == '0);
      if (state_nxt == DRIVE) begin
         seg_raw = (lz_blank && (idx_nxt != '0) && zero_run[idx_nxt]) ? SEG_OFF : cur_seg;
         an_raw  = DIGITS'(1) << idx_nxt;
         dp_raw  = shadow_dp[idx_nxt];
      end
   end

   // Polarity: inactive level is ~cathod, so XOR the active-high value with it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg         <= {7{~cathod}};
         an          <= {DIGITS{~cathod}};
         dp          <= ~cathod;
         other_an    <= {5{~cathod}};
         frame_start <= 1'b0;
      end else begin
         seg         <= seg_raw ^ {7{~cathod}};
         an          <= an_raw ^ {DIGITS{~cathod}};
         dp          <= dp_raw ^ ~cathod;
         other_an    <= {5{~cathod}};
         frame_start <= fs_raw;
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;

   localparam int DIGITS = 3;
   localparam int DWELL  = 4;
   localparam int BLANK  = 2;
   localparam int SLOT   = BLANK + DWELL;
   localparam int FRAME  = DIGITS * SLOT;

   logic        clk       = 1'b0;
   logic        rst       = 1'b1;
   logic        en        = 1'b0;
   logic        cathod    = 1'b0;
   logic        lz_blank  = 1'b0;
   logic        bcd_valid = 1'b0;
   logic [11:0] bcd_in    = '0;
   logic [2:0]  dp_mask   = '0;

   logic        bcd_ready;
   logic [6:0]  seg;
   logic [2:0]  an;
   logic        dp;
   logic [4:0]  other_an;
   logic        frame_start;
   logic [1:0]  digit_idx;

   int n_checks = 0;
   int n_errors = 0;

   seg_scan_ctrl #(
      .DIGITS       (DIGITS),
      .DWELL_CYCLES (DWELL),
      .BLANK_CYCLES (BLANK)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .cathod      (cathod),
      .lz_blank    (lz_blank),
      .bcd_in      (bcd_in),
      .dp_mask     (dp_mask),
      .bcd_valid   (bcd_valid),
      .bcd_ready   (bcd_ready),
      .seg         (seg),
      .an          (an),
      .dp          (dp),
      .other_an    (other_an),
      .frame_start (frame_start),
      .digit_idx   (digit_idx)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Behavioural model: a running flag plus the position inside an 18-cycle
   // frame. Digit = pos / SLOT; the digit is driven when pos % SLOT >= BLANK.
   // ---------------------------------------------------------------------------
   logic [6:0]  seg_table [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
   bit          m_run  = 1'b0;
   int          m_pos  = 0;
   logic [11:0] m_bcd  = '0;
   logic [2:0]  m_dp   = '0;
   logic        m_cath = 1'b0;
   logic        m_lz   = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_run  <= 1'b0;
         m_pos  <= 0;
         m_bcd  <= '0;
         m_dp   <= '0;
         m_cath <= cathod;
         m_lz   <= lz_blank;
      end else begin
         m_cath <= cathod;
         m_lz   <= lz_blank;
         if (bcd_valid && (!m_run || m_pos == FRAME - 1)) begin
            m_bcd <= bcd_in;
            m_dp  <= dp_mask;
         end
         if (!en) begin
            m_run <= 1'b0;
            m_pos <= 0;
         end else if (!m_run) begin
            m_run <= 1'b1;
            m_pos <= 0;
         end else begin
            m_pos <= (m_pos + 1) % FRAME;
         end
      end
   end

   function automatic int cur_d();
      return m_pos / SLOT;
   endfunction

   function automatic bit driving();
      return m_run && ((m_pos % SLOT) >= BLANK);
   endfunction

   function automatic logic [6:0] model_seg(input int d);
      if (m_lz && d > 0 && (m_bcd >> (4 * d)) == 12'd0) return 7'h00;
      return seg_table[m_bcd[4*d +: 4]];
   endfunction

   function automatic logic [6:0] exp_seg();
      return (driving() ? model_seg(cur_d()) : 7'h00) ^ {7{~m_cath}};
   endfunction

   function automatic logic [2:0] exp_an();
      return (driving() ? 3'(1 << cur_d()) : 3'b000) ^ {3{~m_cath}};
   endfunction

   function automatic logic exp_dp();
      return (driving() ? m_dp[cur_d()] : 1'b0) ^ ~m_cath;
   endfunction

   always @(negedge clk) begin
      check("seg",         32'(seg),         32'(exp_seg()));
      check("an",          32'(an),          32'(exp_an()));
      check("dp",          32'(dp),          32'(exp_dp()));
      check("other_an",    32'(other_an),    32'({5{~m_cath}}));
      check("bcd_ready",   32'(bcd_ready),   32'(!m_run || m_pos == FRAME - 1));
      check("frame_start", 32'(frame_start), 32'(m_run && m_pos == 0));
      if (m_run) check("digit_idx", 32'(digit_idx), 32'(cur_d()));
   end

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic start_frame(input logic [11:0] bcd, input logic [2:0] dpm,
                              input logic lz, input logic cath);
      en       = 1'b0;
      cathod   = cath;
      lz_blank = lz;
      tick();
      en        = 1'b1;
      bcd_valid = 1'b1;
      bcd_in    = bcd;
      dp_mask   = dpm;
      tick();
      bcd_valid = 1'b0;
   endtask

   initial begin
      // Reset state, common-anode
      repeat (2) tick();
      check("rst_seg",      32'(seg),         32'h7F);
      check("rst_an",       32'(an),          32'h7);
      check("rst_dp",       32'(dp),          32'h1);
      check("rst_other_an", 32'(other_an),    32'h1F);
      check("rst_ready",    32'(bcd_ready),   32'h1);
      check("rst_fs",       32'(frame_start), 32'h0);
      check("rst_idx",      32'(digit_idx),   32'h0);
      rst = 1'b0;
      repeat (3) tick();
      check("idle_an", 32'(an),          32'h7);
      check("idle_fs", 32'(frame_start), 32'h0);

      // Scan order, common-cathode, dp on digit 1
      start_frame(12'h345, 3'b010, 1'b0, 1'b1);
      check("fs_first", 32'(frame_start), 32'h1);
      check("an_blank", 32'(an),          32'h0);
      repeat (2) tick();
      check("d0_an",  32'(an),  32'h1);
      check("d0_seg", 32'(seg), 32'h6D);
      check("d0_dp",  32'(dp),  32'h0);
      repeat (6) tick();
      check("d1_an",  32'(an),  32'h2);
      check("d1_seg", 32'(seg), 32'h66);
      check("d1_dp",  32'(dp),  32'h1);
      bcd_valid = 1'b1;
      bcd_in    = 12'h999;
      repeat (6) tick();
      check("d2_an",      32'(an),  32'h4);
      check("d2_seg_old", 32'(seg), 32'h4F);
      repeat (2) tick();
      check("ready_low",  32'(bcd_ready), 32'h0);
      tick();
      check("ready_high", 32'(bcd_ready), 32'h1);
      tick();
      bcd_valid = 1'b0;
      check("fs_wrap", 32'(frame_start), 32'h1);
      repeat (2) tick();
      check("new_d0_seg", 32'(seg), 32'h6F);
      repeat (6) tick();
      check("new_d1_seg", 32'(seg), 32'h6F);

      // Polarity flip mid-drive
      cathod = 1'b0;
      tick();
      check("flip_an",       32'(an),       32'h5);
      check("flip_seg",      32'(seg),      32'h10);
      check("flip_dp",       32'(dp),       32'h0);
      check("flip_other_an", 32'(other_an), 32'h1F);
      cathod = 1'b1;
      tick();

      // Asynchronous reset during DRIVE
      #2 rst = 1'b1;
      #1;
      check("arst_an",    32'(an),        32'h0);
      check("arst_seg",   32'(seg),       32'h0);
      check("arst_dp",    32'(dp),        32'h0);
      check("arst_ready", 32'(bcd_ready), 32'h1);
      #1 rst = 1'b0;
      tick();
      check("arst_fs", 32'(frame_start), 32'h1);
      repeat (2) tick();
      check("zero_d0_seg", 32'(seg), 32'h3F);
      repeat (6) tick();
      check("zero_d1_seg", 32'(seg), 32'h3F);

      // en low: IDLE after one edge
      en = 1'b0;
      tick();
      check("enlow_an",    32'(an),        32'h0);
      check("enlow_seg",   32'(seg),       32'h0);
      check("enlow_ready", 32'(bcd_ready), 32'h1);

      // Leading-zero suppression
      start_frame(12'h007, 3'b000, 1'b1, 1'b1);
      repeat (2) tick();
      check("lz_d0_seg", 32'(seg), 32'h07);
      repeat (6) tick();
      check("lz_d1_an",  32'(an),  32'h2);
      check("lz_d1_seg", 32'(seg), 32'h00);
      repeat (6) tick();
      check("lz_d2_an",  32'(an),  32'h4);
      check("lz_d2_seg", 32'(seg), 32'h00);

      // Invalid code, leading zero shown with suppression off
      start_frame(12'h0C7, 3'b000, 1'b0, 1'b1);
      repeat (8) tick();
      check("bad_code_seg", 32'(seg), 32'h00);
      repeat (6) tick();
      check("nolz_d2_seg", 32'(seg), 32'h3F);

      // Randomized phase, checked every cycle by the model
      repeat (3000) begin
         tick();
         en = ($urandom_range(0, 99) < 97);
         if ($urandom_range(0, 49) == 0) cathod = ~cathod;
         if ($urandom_range(0, 19) == 0) lz_blank = ~lz_blank;
         bcd_valid = 1'($urandom_range(0, 1));
         for (int i = 0; i < DIGITS; i++)
            bcd_in[4*i +: 4] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0;
         dp_mask = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 199) == 0) begin
            #2 rst = 1'b1;
            #1 check("rand_arst_an", 32'(an), 32'({3{~cathod}}));
            #1 rst = 1'b0;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
